led_pattern_seq: RTL
====================

Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer. It drives N_LEDS board LEDs from a single system clock. An internal divider produces a one-cycle step strobe, and a frame index advances through one of four selectable patterns: bar fill/drain, bounce, binary count and blink. Run/pause, a runtime speed select and output polarity are all controllable. It sits between the board clock/reset and the LED pins.

Parameters:
N_LEDS, 6, number of LEDs; legal range 2..16.
TICK_DIV, 1350000, clock cycles per step at speed=0; must be >= 8.
DIV_W, 24, divider counter width; must hold TICK_DIV-1.
ACTIVE_LOW, 1, 1 = LED lit drives 0 (output inverted); 0 = lit drives 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  1 = run, 0 = pause (divider and index hold)
mode  input  2  0 FILL, 1 BOUNCE, 2 BINARY, 3 BLINK
speed  input  2  step period = max(1, TICK_DIV >> speed) cycles
step_tick  output  1  one-cycle strobe, high in the cycle leds takes a new frame
frame_idx  output  IDX_W  current index, IDX_W = max(N_LEDS, clog2(2*N_LEDS))
leds  output  N_LEDS  pin drive, polarity per ACTIVE_LOW

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset (rst sampled 1 at a clk edge) sets:
  - div_cnt=0, frame_idx=0, mode_q=0, step_tick=0;
  - logical pattern = all off, so leds = all 1s if ACTIVE_LOW=1, else all 0s.
  - Reset overrides en, mode and speed, including mid-step.
- Divider:
  - period P = TICK_DIV >> speed, clamped to a minimum of 1.
  - With en=1, div_cnt increments each cycle.
  - When div_cnt >= P-1: div_cnt <= 0 and a step occurs. ">=" ensures a speed increase mid-count steps on the next edge with no long wrap.
  - With en=0, div_cnt, frame_idx and leds hold, and step_tick = 0.
- Step (registered, single edge):
  - leds <= polarity(frame(mode_q, frame_idx));
  - frame_idx <= next(mode_q, frame_idx);
  - step_tick <= 1 for exactly that cycle, 0 otherwise.
  - The first frame is displayed on the first step after reset; leds stay blank until then.
- Mode change: on any edge where mode != mode_q and rst=0:
  - mode_q <= mode, frame_idx <= 0, div_cnt <= 0, no step that edge;
  - leds hold the old frame until the next step.
  - The mode change wins over a step coinciding on the same edge.
- Frames (logical, bit0 = LED0), N = N_LEDS:
  - FILL: 2N-1 frames.
    - k = 0..N-1: lowest k+1 bits set.
    - k = N..2N-2: top 2N-1-k bits set (drain from bottom).
    - Wrap 2N-2 -> 0.
  - BOUNCE: 2N-2 frames, single bit lit.
    - Position = k for k < N, else 2N-2-k.
    - Wrap 2N-3 -> 0.
  - BINARY: frame = frame_idx[N-1:0]; wrap 2^N-1 -> 0.
  - BLINK: frame_idx alternates 0/1; 0 = all on, 1 = all off.
- Arithmetic: all index math is unsigned modulo the mode length. frame_idx never leaves its mode's range.
- No combinational path from inputs to leds or step_tick.

Test Plan (TICK_DIV=8, N_LEDS=6, ACTIVE_LOW=0 unless stated):
1. Reset, hold rst 3 cycles, ACTIVE_LOW=1 -> leds=6'b111111, step_tick=0, frame_idx=0. Release, en=1, speed=1 (P=4) -> first step_tick on 4th edge after release, then every 4 cycles, each exactly 1 cycle wide.
2. mode=0, en=1 -> successive steps give leds 000001, 000011, 000111, 001111, 011111, 111111, 111110, 111100, 111000, 110000, 100000, then 000001 (period 11).
3. mode=1 -> 000001, 000010, 000100, 001000, 010000, 100000, 010000, 001000, 000100, 000010, then 000001 (period 10). mode=2 -> 000000..111111, wraps to 000000 after 64 steps.
4. Drop en for 20 cycles mid-FILL at leds=001111 -> no step_tick, leds and frame_idx unchanged. Re-assert en -> next step shows 011111 after the remaining divider count.
5. Change mode 0->3 on the same edge a step is due -> no step, frame_idx=0, old leds held. Next step after P cycles shows 111111, then 000000.
6. speed 0->3 with div_cnt=6 (P drops 8->1) -> step on next edge, then a step every cycle. Assert rst mid-run -> leds blank and frame_idx=0 on that edge.

Source files
------------

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a clock divider issues step strobes that advance a frame index
// through fill/drain, bounce, binary-count or blink patterns on N_LEDS outputs.
module led_pattern_seq #(
    parameter int unsigned N_LEDS     = 6,
    parameter int unsigned TICK_DIV   = 1350000,
    parameter int unsigned DIV_W      = 24,
    parameter bit          ACTIVE_LOW = 1'b1,
    localparam int unsigned IDX_W     = (N_LEDS > 32'($clog2(2 * N_LEDS))) ?
                                        N_LEDS : 32'($clog2(2 * N_LEDS))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic              step_tick,
    output logic [IDX_W-1:0]  frame_idx,
    output logic [N_LEDS-1:0] leds
);

    typedef enum logic [1:0] {ModeFill, ModeBounce, ModeBinary, ModeBlink} mode_e;

    localparam logic [IDX_W-1:0]  FillLast   = IDX_W'(2 * N_LEDS - 2);
    localparam logic [IDX_W-1:0]  BounceLast = IDX_W'(2 * N_LEDS - 3);
    localparam logic [IDX_W-1:0]  BinLast    = IDX_W'((32'd1 << N_LEDS) - 32'd1);
    localparam logic [N_LEDS-1:0] LedsOff    = ACTIVE_LOW ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    mode_e             mode_q, mode_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              tick_q, tick_d;

    logic [31:0]       period;
    logic              step_due;

    function automatic logic [N_LEDS-1:0] frame_of(input mode_e m, input logic [IDX_W-1:0] idx);
        int unsigned k;
        int unsigned pos;
        logic [N_LEDS-1:0] f;
        k   = 32'(idx);
        pos = (k < N_LEDS) ? k : (2 * N_LEDS - 2 - k);
        f   = '0;
        unique case (m)
            ModeFill: begin
                for (int unsigned b = 0; b < N_LEDS; b++) begin
                    f[b] = (k < N_LEDS) ? (b <= k) : (b >= k - N_LEDS + 1);
                end
            end
            ModeBounce: begin
                for (int unsigned b = 0; b < N_LEDS; b++) begin
                    f[b] = (b == pos);
                end
            end
            ModeBinary: f = idx[N_LEDS-1:0];
            ModeBlink:  f = idx[0] ? '0 : '1;
        endcase
        return f;
    endfunction

    function automatic logic [IDX_W-1:0] next_of(input mode_e m, input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] n;
        n = idx + IDX_W'(1);
        unique case (m)
            ModeFill:   if (idx >= FillLast)   n = '0;
            ModeBounce: if (idx >= BounceLast) n = '0;
            ModeBinary: if (idx >= BinLast)    n = '0;
            ModeBlink:  n = idx[0] ? '0 : IDX_W'(1);
        endcase
        return n;
    endfunction

    // ">=" rather than "==" so a faster speed chosen mid-count steps immediately.
    always_comb begin
        period = TICK_DIV >> speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        step_due = (32'(div_cnt_q) >= period - 32'd1);
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        leds_d    = leds_q;
        tick_d    = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            // Mode change restarts the pattern and beats any coincident step.
            mode_d    = mode_e'(mode);
            idx_d     = '0;
            div_cnt_d = '0;
        end else if (en) begin
            if (step_due) begin
                div_cnt_d = '0;
                leds_d    = ACTIVE_LOW ? ~frame_of(mode_q, idx_q) : frame_of(mode_q, idx_q);
                idx_d     = next_of(mode_q, idx_q);
                tick_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            mode_q    <= ModeFill;
            leds_q    <= LedsOff;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            leds_q    <= leds_d;
            tick_q    <= tick_d;
        end
    end

    assign step_tick = tick_q;
    assign frame_idx = idx_q;
    assign leds      = leds_q;

endmodule
